// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: PS/2 scan-code sequencer for the game keys (Up, Down, W, S).
// Decodes E0/F0 prefixes with a small FSM, keeps a held-key bitmap and queues
// press/release events in a FIFO drained by a valid/ready handshake.
// Optional feature macro: KBD_REPEAT_FILTER_EN (suppresses typematic repeats
// and breaks of keys that are not held; key_state is unaffected either way).
module kbd_scan_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [3:0] key_state,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic       evt_press,
  output logic       evt_overflow,
  output logic       err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_UP  = 8'h75;
  localparam logic [7:0] CODE_DN  = 8'h72;
  localparam logic [7:0] CODE_W   = 8'h1D;
  localparam logic [7:0] CODE_S   = 8'h1B;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             expire;

  logic             dec_hit;
  logic [1:0]       dec_key;
  logic             dec_press;
  logic             push;

  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic [2:0]       head;

  // Decode the incoming byte against the current prefix state.
  always_comb begin
    state_nxt = state;
    dec_hit   = 1'b0;
    dec_key   = 2'd0;
    dec_press = 1'b0;
    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_data == CODE_EXT) begin
            state_nxt = ST_EXT;
          end else if (byte_data == CODE_BRK) begin
            state_nxt = ST_BRK;
          end else if (byte_data == CODE_W) begin
            dec_hit = 1'b1; dec_key = 2'd2; dec_press = 1'b1;
          end else if (byte_data == CODE_S) begin
            dec_hit = 1'b1; dec_key = 2'd3; dec_press = 1'b1;
          end
        end
        ST_EXT: begin
          state_nxt = ST_IDLE;
          if (byte_data == CODE_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (byte_data == CODE_EXT) begin
            state_nxt = ST_EXT;
          end else if (byte_data == CODE_UP) begin
            dec_hit = 1'b1; dec_key = 2'd0; dec_press = 1'b1;
          end else if (byte_data == CODE_DN) begin
            dec_hit = 1'b1; dec_key = 2'd1; dec_press = 1'b1;
          end
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          if (byte_data == CODE_W) begin
            dec_hit = 1'b1; dec_key = 2'd2;
          end else if (byte_data == CODE_S) begin
            dec_hit = 1'b1; dec_key = 2'd3;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          if (byte_data == CODE_UP) begin
            dec_hit = 1'b1; dec_key = 2'd0;
          end else if (byte_data == CODE_DN) begin
            dec_hit = 1'b1; dec_key = 2'd1;
          end
        end
      endcase
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign expire = !byte_valid && (state != ST_IDLE) &&
                  (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef KBD_REPEAT_FILTER_EN
  assign push = dec_hit && (key_state[dec_key] != dec_press);
`else
  assign push = dec_hit;
`endif

  // Prefix FSM, inter-byte timeout counter and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (byte_valid) begin
        state   <= state_nxt;
        tmo_cnt <= '0;
      end else if (state == ST_IDLE) begin
        tmo_cnt <= '0;
      end else if (expire) begin
        state       <= ST_IDLE;
        tmo_cnt     <= '0;
        err_timeout <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  // Held-key bitmap; updated on every make/break even when the event is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state <= 4'b0000;
    end else if (dec_hit) begin
      key_state[dec_key] <= dec_press;
    end
  end

  assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop     = evt_valid && evt_ready;
  assign push_ok = push && (!full || pop);

  // Event storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {dec_key, dec_press};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push_ok) begin
        count <= count - (PTR_W + 1)'(1);
      end
      if (push && !push_ok) begin
        evt_overflow <= 1'b1;
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_key   = evt_valid ? head[2:1] : 2'd0;
  assign evt_press = evt_valid ? head[0] : 1'b0;

endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Scan-code sequencer between the PS/2 byte receiver and the game logic.
- Consumes one-cycle byte strobes and tracks E0 (extended) and F0 (break) prefixes with a state machine.
- Maintains held-state for the four game keys (Up, Down, W, S).
- Queues press/release events in a small FIFO drained with a valid/ready handshake. Paddle logic reads either the level bitmap or the event stream.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 100000, clk cycles allowed between a prefix byte and its follow-up byte (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock (CLK100MHZ domain)
- rst  input  1  asynchronous, active-high reset
- byte_valid  input  1  one-cycle strobe; byte_data holds a complete received byte
- byte_data  input  8  scan-code byte
- key_state  output  4  held keys: [0] Up, [1] Down, [2] W, [3] S
- evt_valid  output  1  FIFO head valid (FIFO not empty)
- evt_ready  input  1  consumer accepts the head this cycle
- evt_key  output  2  key index of the head event (encoding as key_state bits)
- evt_press  output  1  1 = press, 0 = release
- evt_overflow  output  1  sticky; an event was dropped because the FIFO was full
- err_timeout  output  1  one-cycle pulse; prefix timeout occurred

Behaviour:
- Reset (async, active-high). All of the following clear immediately: state=IDLE, key_state=0, FIFO empty, evt_valid=0, evt_key=0, evt_press=0, evt_overflow=0, err_timeout=0, timeout counter=0. byte_valid is ignored while rst=1. Reset mid-sequence discards any pending prefix.
- Key map (decided):
  - Up = E0 75, Down = E0 72.
  - W = 1D, S = 1B (non-extended only).
  - Break form = same code preceded by F0 (after E0 for extended keys).
- FSM: states IDLE, EXT, BRK, EXT_BRK. Transitions occur only on byte_valid.
  - IDLE: E0 -> EXT; F0 -> BRK; 1D/1B -> make W/S, stay; any other byte -> ignored, stay.
  - EXT: F0 -> EXT_BRK; 75/72 -> make Up/Down, -> IDLE; E0 -> stay EXT; other -> IDLE, ignored.
  - BRK: 1D/1B -> break W/S, -> IDLE; other -> IDLE, ignored.
  - EXT_BRK: 75/72 -> break Up/Down, -> IDLE; other -> IDLE, ignored.
  - 1D/1B received in EXT or EXT_BRK do not map to W/S.
- Make: sets key_state bit and pushes {key, press=1}. Break: clears the bit and pushes {key, press=0}.
- Latency: byte_valid in cycle n gives key_state update and FIFO push in cycle n+1. With an empty FIFO, evt_valid=1 in cycle n+1.
- Timeout: the counter runs only in EXT, BRK and EXT_BRK, and clears on every byte_valid and on entry to IDLE. When the counter reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and err_timeout pulses high for 1 cycle. A byte_valid arriving in the expiry cycle wins: it is processed normally and no timeout pulse occurs.
- FIFO: pop occurs when evt_valid && evt_ready. The head outputs are stable while evt_valid=1 and evt_ready=0.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Push to a full FIFO with no pop: the event is dropped, evt_overflow is set (sticky until rst), and key_state still updates.
  - Pop on an empty FIFO is a no-op.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; the count is one bit wider.
- key_state is authoritative regardless of FIFO drops.

Optional Feature:
- Macro: KBD_REPEAT_FILTER_EN.
- Defined: a make code for a key whose key_state bit is already 1 (typematic repeat) pushes no event. key_state is unchanged. The same rule applies to a break for a key that is not held: no event.
- Undefined: every make/break pushes an event unconditionally.

Test Plan:
- Bytes 1D, then F0 1D, evt_ready=1 -> key_state[2] rises one cycle after the 1D strobe and clears after 1D of the break. Events {2,1}, {2,0} in order.
- Bytes E0 75, E0 72, E0 F0 75 -> key_state goes 0001, 0011, 0010. Three events {0,1}, {1,1}, {0,0}.
- evt_ready=0, FIFO_DEPTH=4, six W/S make/break bytes -> four events retained, evt_overflow=1, key_state correct. Then drain with evt_ready=1 -> original four events in order; evt_overflow stays 1.
- Byte E0, then idle for TIMEOUT_CYCLES cycles, then byte 1D -> err_timeout pulses once; 1D decodes as make W, not as an extended key.
- FIFO full and a push coincides with a pop -> push is accepted and count unchanged. Assert rst mid E0 F0 sequence, then send 75 -> no Up event; all outputs 0 during reset.
- With KBD_REPEAT_FILTER_EN defined, bytes 1B 1B 1B F0 1B -> exactly two events {3,1}, {3,0}. Undefined -> four events.
